accum4_ctrl: RTL and testbench

//   Sequencing/accumulator stage wrapped around the addsub4 datapath. Accepts one operation at a time
//   (load/add/sub/clear) with an operand. Drives addsub4's A/B/m with the accumulator, the registered

---
 rtl/accum_pkg.sv | 8 +
 rtl/accum4_ctrl_if.sv | 22 ++
 rtl/accum_sat.sv | 11 +
 rtl/addsub4.sv | 14 +
 rtl/accum4_ctrl.sv | 72 +++++++
 tb/tb_accum4_ctrl.sv | 182 ++++++++++++++++++
 6 files changed

// File: rtl/accum_pkg.sv
// accum_pkg: op-code constants and FSM state encoding shared by the accumulator, operand-entry and display stages.
package accum_pkg;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    typedef enum logic {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_t;
endpackage

// File: rtl/accum4_ctrl_if.sv
// accum4_ctrl_if: operation request, status and addsub4 datapath bus of the accumulator stage.
interface accum4_ctrl_if #(parameter int WIDTH = 4);
    logic             op_valid;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] as_a;
    logic [WIDTH-1:0] as_b;
    logic             as_m;
    logic [WIDTH-1:0] sum_s;
    logic             sum_cout;
    logic             sum_vout;
    logic [WIDTH-1:0] acc;
    logic             carry_flg;
    logic             ovf_flg;
    logic             ovf_sticky;
    logic             busy;
    logic             done;
    modport master (output op_valid, op_code, operand, sum_s, sum_cout, sum_vout,
                    input as_a, as_b, as_m, acc, carry_flg, ovf_flg, ovf_sticky, busy, done);
    modport slave  (input op_valid, op_code, operand, sum_s, sum_cout, sum_vout,
                    output as_a, as_b, as_m, acc, carry_flg, ovf_flg, ovf_sticky, busy, done);
endinterface

// File: rtl/accum_sat.sv
// accum_sat: clamps an overflowed result to signed max/min by the accumulator sign; built only with ACCUM_SATURATE_EN.
`ifdef ACCUM_SATURATE_EN
module accum_sat #(parameter int WIDTH = 4) (
    input  logic [WIDTH-1:0] sum,
    input  logic             vout,
    input  logic             a_msb,
    output logic [WIDTH-1:0] result
);
    assign result = !vout ? sum : a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
endmodule
`endif

// File: rtl/addsub4.sv
// addsub4: 4-bit two's complement adder/subtractor (m=1 subtracts), with carry-out and signed overflow.
module addsub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       m,
    output logic [3:0] s,
    output logic       cout,
    output logic       vout
);
    logic [3:0] bx;
    assign bx = b ^ {4{m}};
    assign {cout, s} = {1'b0, a} + {1'b0, bx} + {4'b0, m};
    assign vout = (a[3] == bx[3]) && (s[3] != a[3]);
endmodule

// File: rtl/accum4_ctrl.sv
// accum4_ctrl: load/add/sub/clear accumulator sequencing an external addsub4.
// Define ACCUM_SATURATE_EN to saturate overflowing ADD/SUB results instead of wrapping.
module accum4_ctrl
    import accum_pkg::*;
#(parameter int WIDTH = 4) (
    input logic         clk,
    input logic         rst,
    accum4_ctrl_if.slave bus
);
    state_t           state, nxt;
    logic [WIDTH-1:0] acc, as_b, result;
    logic             as_m, carry, ovf, sticky, done, arith;
    assign arith = bus.op_code == OP_ADD || bus.op_code == OP_SUB;
`ifdef ACCUM_SATURATE_EN
    accum_sat #(.WIDTH(WIDTH)) u_sat (
        .sum   (bus.sum_s),
        .vout  (bus.sum_vout),
        .a_msb (acc[WIDTH-1]),
        .result(result)
    );
`else
    assign result = bus.sum_s;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    always_comb begin
        nxt = state;
        nxt = state == ST_EXEC ? ST_IDLE : (bus.op_valid && arith) ? ST_EXEC : ST_IDLE;
    end
    // The adder sees acc/as_b/as_m for the whole EXEC cycle, so its outputs are settled at the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            as_b   <= '0;
            as_m   <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            sticky <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_EXEC) begin
                acc    <= result;
                carry  <= bus.sum_cout;
                ovf    <= bus.sum_vout;
                sticky <= sticky | bus.sum_vout;
                done   <= 1'b1;
            end else if (bus.op_valid) begin
                if (arith) begin
                    as_b <= bus.operand;
                    as_m <= bus.op_code == OP_SUB;
                end else begin
                    acc    <= bus.op_code == OP_LOAD ? bus.operand : '0;
                    carry  <= 1'b0;
                    ovf    <= 1'b0;
                    sticky <= bus.op_code == OP_LOAD ? sticky : 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end
    assign bus.acc        = acc;
    assign bus.as_a       = acc;
    assign bus.as_b       = as_b;
    assign bus.as_m       = as_m;
    assign bus.carry_flg  = carry;
    assign bus.ovf_flg    = ovf;
    assign bus.ovf_sticky = sticky;
    assign bus.done       = done;
    assign bus.busy       = state == ST_EXEC;
endmodule

// File: tb/tb_accum4_ctrl.sv
// tb_accum4_ctrl: directed and random ops on accum4_ctrl + addsub4 against an integer arithmetic model.
module tb_accum4_ctrl;
    import accum_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int m_acc, m_c, m_v, m_s;
    accum4_ctrl_if #(.WIDTH(4)) intf ();
    accum4_ctrl #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(intf.slave));
    addsub4 u_as (
        .a(intf.as_a), .b(intf.as_b), .m(intf.as_m),
        .s(intf.sum_s), .cout(intf.sum_cout), .vout(intf.sum_vout)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask
    function automatic void model(input logic [1:0] c, input int b);
        int sa, sb, r, sr;
        sa = m_acc > 7 ? m_acc - 16 : m_acc;
        sb = b > 7 ? b - 16 : b;
        if (c == OP_LOAD) begin
            m_acc = b; m_c = 0; m_v = 0;
        end else if (c == OP_CLEAR) begin
            m_acc = 0; m_c = 0; m_v = 0; m_s = 0;
        end else begin
            r  = c == OP_ADD ? m_acc + b : m_acc + 16 - b;
            sr = c == OP_ADD ? sa + sb : sa - sb;
            m_c = r > 15 ? 1 : 0;
            m_v = (sr > 7 || sr < -8) ? 1 : 0;
            m_s = m_s | m_v;
`ifdef ACCUM_SATURATE_EN
            m_acc = m_v ? (sa >= 0 ? 7 : 8) : r % 16;
`else
            m_acc = r % 16;
`endif
        end
    endfunction
    task automatic chk_state(input string tag);
        chk({tag, "_acc"}, intf.acc, m_acc);
        chk({tag, "_as_a"}, intf.as_a, m_acc);
        chk({tag, "_carry"}, intf.carry_flg, m_c);
        chk({tag, "_ovf"}, intf.ovf_flg, m_v);
        chk({tag, "_sticky"}, intf.ovf_sticky, m_s);
    endtask
    task automatic run_op(input logic [1:0] c, input logic [3:0] v);
        @(negedge clk);
        intf.op_valid = 1'b1;
        intf.op_code  = c;
        intf.operand  = v;
        @(posedge clk);
        #1;
        intf.op_valid = 1'b0;
        if (c == OP_ADD || c == OP_SUB) begin
            chk("exec_busy", intf.busy, 1);
            chk("exec_done", intf.done, 0);
            chk("exec_as_b", intf.as_b, v);
            chk("exec_as_m", intf.as_m, c == OP_SUB);
            chk("exec_acc_hold", intf.acc, m_acc);
            @(posedge clk);
            #1;
        end
        model(c, v);
        chk("commit_done", intf.done, 1);
        chk("commit_busy", intf.busy, 0);
        chk_state("commit");
        @(posedge clk);
        #1;
        chk("after_done", intf.done, 0);
        chk_state("after");
    endtask
    initial begin
        intf.op_valid = 1'b0;
        intf.op_code  = OP_LOAD;
        intf.operand  = 4'd0;
        m_acc = 0; m_c = 0; m_v = 0; m_s = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset");
        chk("reset_busy", intf.busy, 0);
        chk("reset_done", intf.done, 0);
        chk("reset_as_b", intf.as_b, 0);
        chk("reset_as_m", intf.as_m, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(OP_LOAD, 4'b0101);
        chk("t1_acc", intf.acc, 4'b0101);
        run_op(OP_ADD, 4'b0011);
`ifdef ACCUM_SATURATE_EN
        chk("t2_acc", intf.acc, 4'b0111);
`else
        chk("t2_acc", intf.acc, 4'b1000);
`endif
        chk("t2_ovf", intf.ovf_flg, 1);
        chk("t2_sticky", intf.ovf_sticky, 1);
        run_op(OP_LOAD, 4'b1000);
        run_op(OP_ADD, 4'b0001);
        chk("t6_ovf", intf.ovf_flg, 0);
        chk("t6_sticky", intf.ovf_sticky, 1);
        run_op(OP_CLEAR, 4'b1111);
        chk("t6_clear_acc", intf.acc, 0);
        chk("t6_clear_sticky", intf.ovf_sticky, 0);
        run_op(OP_LOAD, 4'b0010);
        run_op(OP_SUB, 4'b0110);
        chk("t3_acc", intf.acc, 4'b1100);
        chk("t3_carry", intf.carry_flg, 0);
        run_op(OP_SUB, 4'b0001);
        chk("t3b_acc", intf.acc, 4'b1011);
        chk("t3b_carry", intf.carry_flg, 1);
        // op_valid held across EXEC with op_code switched mid-EXEC
        @(negedge clk);
        intf.op_valid = 1'b1;
        intf.op_code  = OP_ADD;
        intf.operand  = 4'd1;
        @(posedge clk);
        #1;
        chk("t4_busy0", intf.busy, 1);
        intf.op_code = OP_SUB;
        intf.operand = 4'd3;
        @(posedge clk);
        #1;
        model(OP_ADD, 1);
        chk("t4_done1", intf.done, 1);
        chk_state("t4_add");
        @(posedge clk);
        #1;
        chk("t4_busy2", intf.busy, 1);
        chk("t4_done2", intf.done, 0);
        chk("t4_as_m", intf.as_m, 1);
        chk("t4_acc_hold", intf.acc, m_acc);
        @(posedge clk);
        #1;
        intf.op_valid = 1'b0;
        model(OP_SUB, 3);
        chk("t4_done3", intf.done, 1);
        chk_state("t4_sub");
        @(posedge clk);
        #1;
        chk("t4_idle_busy", intf.busy, 0);
        chk_state("t4_idle");
        // reset in the middle of EXEC
        run_op(OP_LOAD, 4'b0101);
        @(negedge clk);
        intf.op_valid = 1'b1;
        intf.op_code  = OP_ADD;
        intf.operand  = 4'b0011;
        @(posedge clk);
        #1;
        intf.op_valid = 1'b0;
        chk("t5_busy", intf.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        m_acc = 0; m_c = 0; m_v = 0; m_s = 0;
        chk_state("t5_rst");
        chk("t5_rst_busy", intf.busy, 0);
        chk("t5_rst_done", intf.done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("t5_post_busy", intf.busy, 0);
            chk("t5_post_done", intf.done, 0);
            chk_state("t5_post");
        end
        for (int i = 0; i < 300; i++)
            run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
